// File: rtl/char_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// char_buffer_ctrl
//
// Owns the 16x16 character-code buffer read by the start-screen text drawer.
// All writes are sequenced through one command port: clear the buffer, set
// the write cursor, or put a character at the cursor. Writes can be confined
// to vertical blanking so the visible frame never tears.
//
// Ports:
//   clk        in   pixel clock
//   rst        in   asynchronous, active-high reset
//   vblnk      in   vertical blanking from the timing chain
//   rd_addr    in   [7:0] read address {row, col} from the drawer's char_xy
//   rd_code    out  [6:0] character code at rd_addr, registered (1-cycle latency)
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted this cycle
//   cmd_op     in   [1:0] 0 NOP, 1 CLEAR, 2 SETPOS, 3 PUTC
//   cmd_data   in   [7:0] SETPOS: new cursor; PUTC: [6:0] code or 8'h0A newline
//   busy       out  CLEAR sequence in progress (registered)
//   cursor     out  [7:0] current write cursor {row, col} (registered)
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. The writer holds cmd_op/cmd_data stable while
// cmd_valid is high and cmd_ready is low; nothing is dropped or taken early.
// cmd_ready depends only on the current state and vblnk, never on cmd_valid.
//
// The FSM state and the clear address are kept in the named registers
// "state" and "clr_addr" so they can be observed hierarchically.
// ---------------------------------------------------------------------------
module char_buffer_ctrl #(
   parameter bit         WRITE_IN_VBLANK = 1'b1,
   parameter logic [6:0] FILL_CODE       = 7'h20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vblnk,
   input  logic [7:0] rd_addr,
   output logic [6:0] rd_code,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_data,
   output logic       busy,
   output logic [7:0] cursor
);

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_CLEAR = 2'd1,
      ST_IDLE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_NOP    = 2'd0,
      OP_CLEAR  = 2'd1,
      OP_SETPOS = 2'd2,
      OP_PUTC   = 2'd3
   } op_t;

   localparam logic [7:0] NEWLINE = 8'h0A;

   state_t     state;
   logic [7:0] clr_addr;

   // Buffer storage; deliberately not reset, the power-up clear fills it.
   logic [6:0] ram [0:255];

   logic       wr_window;
   logic       accept;
   logic       ram_we;
   logic [7:0] ram_waddr;
   logic [6:0] ram_wdata;

   // Writes (clear or command) are only allowed inside the window.
   assign wr_window = !WRITE_IN_VBLANK || vblnk;
   assign cmd_ready = (state == ST_IDLE) && wr_window;
   assign accept    = cmd_valid && cmd_ready;

   // Single RAM write port shared by the clear sequencer and PUTC.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = clr_addr;
      ram_wdata = FILL_CODE;
      if (state == ST_CLEAR) begin
         ram_we = wr_window;
      end else if (accept && (cmd_op == OP_PUTC) && (cmd_data != NEWLINE)) begin
         ram_we    = 1'b1;
         ram_waddr = cursor;
         ram_wdata = cmd_data[6:0];
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[ram_waddr] <= ram_wdata;
      end
   end

   // Control FSM plus registered read port. rd_code samples the RAM with the
   // same edge that commits a write, so a same-address hit returns old data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_RST;
         rd_code  <= 7'd0;
         cursor   <= 8'd0;
         busy     <= 1'b0;
         clr_addr <= 8'd0;
      end else begin
         rd_code <= ram[rd_addr];
         case (state)
            ST_RST: begin
               state    <= ST_CLEAR;
               busy     <= 1'b1;
               clr_addr <= 8'd0;
            end
            ST_CLEAR: begin
               // Outside the write window the sequence simply pauses.
               if (wr_window) begin
                  if (clr_addr == 8'hFF) begin
                     clr_addr <= 8'd0;
                     cursor   <= 8'd0;
                     busy     <= 1'b0;
                     state    <= ST_IDLE;
                  end else begin
                     clr_addr <= clr_addr + 8'd1;
                  end
               end
            end
            ST_IDLE: begin
               if (accept) begin
                  case (cmd_op)
                     OP_CLEAR: begin
                        state    <= ST_CLEAR;
                        busy     <= 1'b1;
                        clr_addr <= 8'd0;
                     end
                     OP_SETPOS: begin
                        cursor <= cmd_data;
                     end
                     OP_PUTC: begin
                        if (cmd_data == NEWLINE) begin
                           // Start of next row; row 15 wraps to row 0.
                           cursor <= {cursor[7:4] + 4'd1, 4'h0};
                        end else begin
                           cursor <= cursor + 8'd1;
                        end
                     end
                     default: begin
                     end
                  endcase
               end
            end
            default: begin
               state <= ST_RST;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_char_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_char_buffer_ctrl
//
// Directed bench for char_buffer_ctrl (WRITE_IN_VBLANK=1, FILL_CODE=7'h20).
// Inputs change 1 ns after the rising clk edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_char_buffer_ctrl;

   localparam logic [1:0] OP_NOP    = 2'd0;
   localparam logic [1:0] OP_CLEAR  = 2'd1;
   localparam logic [1:0] OP_SETPOS = 2'd2;
   localparam logic [1:0] OP_PUTC   = 2'd3;

   logic       clk;
   logic       rst;
   logic       vblnk;
   logic [7:0] rd_addr;
   logic [6:0] rd_code;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data;
   logic       busy;
   logic [7:0] cursor;

   int n_checks = 0;
   int n_fail   = 0;

   char_buffer_ctrl #(
      .WRITE_IN_VBLANK(1'b1),
      .FILL_CODE      (7'h20)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .vblnk    (vblnk),
      .rd_addr  (rd_addr),
      .rd_code  (rd_code),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op   (cmd_op),
      .cmd_data (cmd_data),
      .busy     (busy),
      .cursor   (cursor)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a command for one edge; valid is left high so calls chain
   // back-to-back. The caller drops cmd_valid when the burst ends.
   task automatic send(input logic [1:0] op, input logic [7:0] data);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      tick();
   endtask

   task automatic read_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
      rd_addr = addr;
      tick();
      check(tag, {1'b0, rd_code}, exp);
   endtask

   // Counts edges after which busy is high, stopping on its falling edge.
   task automatic count_busy(output int cnt);
      cnt = 0;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (busy) cnt++;
         else if (cnt > 0) break;
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int cnt;
      int hi;

      rst       = 1'b1;
      vblnk     = 1'b1;
      rd_addr   = 8'h00;
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
      cmd_data  = 8'h00;

      // Reset state
      repeat (3) tick();
      check("rst_rd_code",   {1'b0, rd_code}, 8'h00);
      check("rst_cursor",    cursor,          8'h00);
      check("rst_busy",      {7'd0, busy},    8'h00);
      check("rst_cmd_ready", {7'd0, cmd_ready}, 8'h00);
      check("rst_clr_addr",  dut.clr_addr,    8'h00);

      // Power-up clear with vblnk held high: busy for exactly 256 cycles
      rst = 1'b0;
      count_busy(cnt);
      check("pwrup_busy_cycles_lo", cnt[7:0], 8'h00);
      check("pwrup_busy_cycles_hi", cnt[15:8], 8'h01);
      check("pwrup_cmd_ready", {7'd0, cmd_ready}, 8'h01);
      check("pwrup_cursor",    cursor,          8'h00);

      // Every cell holds the fill code, one cycle after its address
      for (int a = 0; a < 256; a++) begin
         read_check($sformatf("fill_rd_%02h", a), 8'(a), 8'h20);
      end

      // SETPOS 1E then back-to-back PUTC 'A','B','C' across a row boundary
      send(OP_SETPOS, 8'h1E);
      check("setpos_1e_cursor", cursor, 8'h1E);
      send(OP_PUTC, 8'h41);
      send(OP_PUTC, 8'h42);
      send(OP_PUTC, 8'h43);
      cmd_valid = 1'b0;
      check("abc_cursor", cursor, 8'h21);
      read_check("abc_rd_1e", 8'h1E, 8'h41);
      read_check("abc_rd_1f", 8'h1F, 8'h42);
      read_check("abc_rd_20", 8'h20, 8'h43);
      read_check("abc_rd_1d", 8'h1D, 8'h20);

      // Cursor wrap from FF to 00
      send(OP_SETPOS, 8'hFE);
      send(OP_PUTC, 8'h31);
      send(OP_PUTC, 8'h32);
      send(OP_PUTC, 8'h33);
      cmd_valid = 1'b0;
      check("wrap_cursor", cursor, 8'h01);
      read_check("wrap_rd_fe", 8'hFE, 8'h31);
      read_check("wrap_rd_ff", 8'hFF, 8'h32);
      read_check("wrap_rd_00", 8'h00, 8'h33);
      read_check("wrap_rd_01", 8'h01, 8'h20);

      // Newline from row 15 wraps to row 0, no RAM write
      send(OP_SETPOS, 8'hF7);
      send(OP_PUTC, 8'h0A);
      cmd_valid = 1'b0;
      check("nl_wrap_cursor", cursor, 8'h00);
      read_check("nl_rd_f7", 8'hF7, 8'h20);
      read_check("nl_rd_00", 8'h00, 8'h33);

      // Newline mid-grid goes to start of next row
      send(OP_SETPOS, 8'h35);
      send(OP_PUTC, 8'h0A);
      cmd_valid = 1'b0;
      check("nl_mid_cursor", cursor, 8'h40);

      // NOP leaves cursor alone
      send(OP_NOP, 8'h99);
      cmd_valid = 1'b0;
      check("nop_cursor", cursor, 8'h40);

      // Read-first on a same-address write/read
      rd_addr = 8'h40;
      send(OP_PUTC, 8'h55);
      cmd_valid = 1'b0;
      check("rfirst_old", {1'b0, rd_code}, 8'h20);
      check("rfirst_cursor", cursor, 8'h41);
      tick();
      check("rfirst_new", {1'b0, rd_code}, 8'h55);

      // Command held while vblnk is low: not accepted, not lost
      vblnk = 1'b0;
      #1;
      check("idle_noblank_ready", {7'd0, cmd_ready}, 8'h00);
      cmd_valid = 1'b1;
      cmd_op    = OP_PUTC;
      cmd_data  = 8'h66;
      repeat (3) tick();
      check("held_cursor", cursor, 8'h41);
      vblnk = 1'b1;
      #1;
      check("held_ready", {7'd0, cmd_ready}, 8'h01);
      tick();
      cmd_valid = 1'b0;
      check("held_accept_cursor", cursor, 8'h42);
      read_check("held_rd_41", 8'h41, 8'h66);

      // CLEAR command with vblnk 100 high / 50 low: clr_addr tracks high cycles
      send(OP_CLEAR, 8'h00);
      cmd_valid = 1'b0;
      check("clr_busy", {7'd0, busy}, 8'h01);
      hi = 0;
      for (int k = 0; k < 1000; k++) begin
         vblnk = ((k % 150) < 100);
         if (vblnk) hi++;
         tick();
         if (!busy) break;
         check($sformatf("clr_addr_k%0d", k), dut.clr_addr, 8'(hi));
         if (!vblnk) check($sformatf("clr_ready_k%0d", k), {7'd0, cmd_ready}, 8'h00);
      end
      check("clr_hi_cycles_lo", hi[7:0], 8'h00);
      check("clr_hi_cycles_hi", hi[15:8], 8'h01);
      check("clr_end_cursor", cursor, 8'h00);
      check("clr_end_addr", dut.clr_addr, 8'h00);
      vblnk = 1'b0;
      #1;
      check("clr_idle_ready_low", {7'd0, cmd_ready}, 8'h00);
      vblnk = 1'b1;
      #1;
      check("clr_idle_ready_high", {7'd0, cmd_ready}, 8'h01);
      read_check("clr_rd_1e", 8'h1E, 8'h20);
      read_check("clr_rd_41", 8'h41, 8'h20);

      // Reset in the middle of a clear, at clr_addr = 100
      send(OP_SETPOS, 8'h77);
      send(OP_CLEAR, 8'h00);
      cmd_valid = 1'b0;
      rd_addr = 8'h10;
      for (int k = 0; k < 300; k++) begin
         if (dut.clr_addr == 8'd100) break;
         tick();
      end
      check("mid_clr_addr", dut.clr_addr, 8'd100);
      check("mid_cursor", cursor, 8'h77);
      check("mid_rd_code", {1'b0, rd_code}, 8'h20);
      rst = 1'b1;
      #1;
      check("async_rd_code",   {1'b0, rd_code}, 8'h00);
      check("async_cursor",    cursor,          8'h00);
      check("async_busy",      {7'd0, busy},    8'h00);
      check("async_cmd_ready", {7'd0, cmd_ready}, 8'h00);
      check("async_clr_addr",  dut.clr_addr,    8'h00);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      check("reclr_start_addr", dut.clr_addr, 8'h00);
      check("reclr_start_busy", {7'd0, busy}, 8'h01);
      count_busy(cnt);
      // count_busy started one edge late, so it sees 255 busy edges
      check("reclr_busy_cycles", cnt[7:0], 8'd255);
      check("reclr_cursor", cursor, 8'h00);
      read_check("reclr_rd_ff", 8'hFF, 8'h20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/char_buffer_ctrl.md
Name: char_buffer_ctrl

Overview:
- Owns the 16x16 character-code buffer that the start-screen text drawer reads through its 8-bit `char_xy` address.
- Sequences all writes into that buffer from game/menu logic through a valid/ready command port: clear, set cursor, put character.
- Writes can be confined to vertical blanking so the visible frame never tears.
- Sits between the menu FSM (writer) and the char drawer + font ROM (reader).

Parameters:
- WRITE_IN_VBLANK, 1, 1 = commands accepted and clear writes performed only while `vblnk`=1; 0 = at any time.
- FILL_CODE, 7'h20, character code written to every cell by CLEAR.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- vblnk  in  1  vertical blanking from the timing chain.
- rd_addr  in  8  read address {row[3:0], col[3:0]}, driven by the drawer's `char_xy`.
- rd_code  out  7  character code at `rd_addr`, registered.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_op  in  2  0 = NOP, 1 = CLEAR, 2 = SETPOS, 3 = PUTC.
- cmd_data  in  8  SETPOS: new cursor; PUTC: [6:0] code, or 8'h0A = newline.
- busy  out  1  CLEAR sequence in progress.
- cursor  out  8  current write cursor {row, col}.

Behaviour:
Reset (async assert):
- state = RST, `rd_code` = 0, `cursor` = 0, `busy` = 0, `cmd_ready` = 0, clear address = 0.
- Buffer RAM contents are not reset.

States:
- RST: on the first clk edge after `rst` deasserts, go to CLEAR. This is an automatic power-up clear.
- CLEAR:
  - `busy` = 1, `cmd_ready` = 0.
  - Each write-enabled cycle writes FILL_CODE to ram[clr_addr], then clr_addr += 1.
  - Write-enabled means `vblnk`=1, or WRITE_IN_VBLANK=0.
  - When `vblnk`=0 and WRITE_IN_VBLANK=1, the sequence pauses: no write, clr_addr holds.
  - After the write to address 255: clr_addr = 0, `cursor` = 0, go to IDLE.
  - Total is exactly 256 write-enabled cycles.
- IDLE:
  - `cmd_ready` = 1 when WRITE_IN_VBLANK=0, or when `vblnk`=1. It is a combinational function of state and `vblnk`.
  - A command is accepted on a clk edge where `cmd_valid` && `cmd_ready`.

Commands (on acceptance):
- NOP: no effect.
- CLEAR: go to CLEAR next cycle.
- SETPOS: `cursor` <= `cmd_data`.
- PUTC, `cmd_data` != 8'h0A:
  - ram[cursor] <= `cmd_data[6:0]`.
  - `cursor` <= cursor + 1, modulo 256, so 8'hFF wraps to 8'h00.
  - Column 15 rolls into column 0 of the next row.
- PUTC, `cmd_data` == 8'h0A:
  - No write.
  - `cursor` <= {cursor[7:4] + 1, 4'h0}; row 15 wraps to row 0.

Back-to-back and held commands:
- Back-to-back PUTC is allowed every cycle; throughput is one command per clk while `cmd_ready` is high.
- Commands presented while `cmd_ready`=0 are held by the writer: not lost, not accepted.

Read port:
- `rd_code` <= ram[rd_addr] every clk, independent of state. Latency is 1 cycle.
- If a write and a read hit the same address in the same cycle, `rd_code` returns the old data (read-first).

Other rules:
- `busy` and `cursor` are registered.
- A reset asserted mid-CLEAR or mid-command aborts immediately. A new full clear runs after release.

Test Plan:
- Reset, then release with `vblnk`=1 constant: `busy`=1 for exactly 256 cycles. Then `busy`=0, `cmd_ready`=1, `cursor`=0. Reading addresses 0..255 gives 7'h20 on each `rd_code`, one cycle after the address.
- WRITE_IN_VBLANK=1, `vblnk` toggled 100 cycles high / 50 low: clear finishes after 256 high cycles. clr_addr is frozen during low phases. `cmd_ready` stays 0 whenever `vblnk`=0, even in IDLE.
- SETPOS 8'h1E, then PUTC 'A' (0x41), 'B', 'C' on consecutive cycles: ram[0x1E]=0x41, ram[0x1F]=0x42, ram[0x20]=0x43, `cursor`=0x21.
- SETPOS 8'hFE, then PUTC 0x31, 0x32, 0x33: the writes land at 0xFE, 0xFF, 0x00 and `cursor`=0x01. Next, SETPOS 8'hF7 followed by PUTC 0x0A gives `cursor`=0x00 with no RAM write.
- `rd_addr`=0x40 held while PUTC 0x55 is accepted at `cursor`=0x40: `rd_code` shows the old value on the next cycle and 0x55 on the cycle after.
- `rst` pulsed during CLEAR at clr_addr=100: outputs return to reset values asynchronously. After release, a full 256-cycle clear runs again from address 0.
